sl_rx_deframer: RTL and testbench

- Receive end of the two-wire SL link (sl0/sl1, both idle high).
- Decodes return-to-idle symbol pulses into data words, checks odd parity and framing, and presents each word with a valid/ack handshake toward the APB-side bridge logic.
- Word length is selected by mode, using the same encoding as the SL transmitter.

---
 rtl/sl_rx_deframer.sv | 208 ++++++++++++++++++++
 tb/tb_sl_rx_deframer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sl_rx_deframer.sv
// SL link receiver: decodes return-to-idle pulses on sl0/sl1 into framed words (optional idle timeout: SL_RX_TIMEOUT_EN).
// Latency: raw release of the STOP pulse to valid rise is SYNC_STAGES+1 clk cycles.
// Backpressure: none toward the line; an unacked word is overwritten on the next commit and overrun_err pulses.
`timescale 1ns/1ps
module sl_rx_deframer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sl0,
  input  logic        sl1,
  input  logic [1:0]  mode,
  output logic [31:0] data,
  output logic        valid,
  input  logic        ack,
  output logic        ready,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAR,
    ST_STOP_W,
    ST_SKIP
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync0, sync1;
  logic        s0, s1, lines_idle;
  logic        lo0, lo1;
  logic        sym_vld, sym_stop, sym_bit;
  logic [31:0] shift;
  logic [5:0]  cnt;
  logic [1:0]  len_q;
  logic [5:0]  nbits;
  logic        par_bit, parity_ok;
  logic        start, shift_en, par_ld, commit, perr_nxt, ferr_nxt;
  logic        timeout;

  // Input synchronizers; idle-high reset so a reset never looks like a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= '1;
      sync1 <= '1;
    end else begin
      sync0 <= {sync0[SYNC_STAGES-2:0], sl0};
      sync1 <= {sync1[SYNC_STAGES-2:0], sl1};
    end
  end

  assign s0         = sync0[SYNC_STAGES-1];
  assign s1         = sync1[SYNC_STAGES-1];
  assign lines_idle = s0 & s1;

  // Accumulate which lines went low during the current pulse; skew between lines is absorbed here.
  always_ff @(posedge clk) begin
    if (reset || lines_idle) begin
      lo0 <= 1'b0;
      lo1 <= 1'b0;
    end else begin
      lo0 <= lo0 | ~s0;
      lo1 <= lo1 | ~s1;
    end
  end

  // A symbol is complete on the first idle cycle after any low level was seen.
  assign sym_vld  = lines_idle & (lo0 | lo1);
  assign sym_stop = lo0 & lo1;
  assign sym_bit  = lo1;

  assign nbits     = {1'b0, len_q, 3'b000} + 6'd8;
  assign parity_ok = ^{shift, par_bit};

`ifdef SL_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // Count consecutive idle-line cycles while a frame is open; any pulse restarts the count.
  always_ff @(posedge clk) begin
    if (reset || state == ST_IDLE || !lines_idle) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout = (state != ST_IDLE) && lines_idle &&
                   (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout        = 1'b0;
`endif

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-symbol control; at most one error flag per symbol.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    par_ld    = 1'b0;
    commit    = 1'b0;
    perr_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    if (timeout) begin
      ferr_nxt  = 1'b1;
      state_nxt = ST_IDLE;
    end else if (sym_vld) begin
      case (state)
        ST_IDLE: begin
          if (!sym_stop) begin
            start     = 1'b1;
            state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          if (sym_stop) begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            shift_en = 1'b1;
            if (cnt + 6'd1 == nbits) state_nxt = ST_PAR;
          end
        end
        ST_PAR: begin
          if (sym_stop) begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            par_ld    = 1'b1;
            state_nxt = ST_STOP_W;
          end
        end
        ST_STOP_W: begin
          if (sym_stop) begin
            commit    = parity_ok;
            perr_nxt  = ~parity_ok;
            state_nxt = ST_IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (sym_stop) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Shift register, bit counter and latched length; separate from data so reception runs while valid=1.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift   <= '0;
      cnt     <= '0;
      len_q   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (start) begin
        len_q <= mode;
        shift <= {31'b0, sym_bit};
        cnt   <= 6'd1;
      end else if (shift_en) begin
        shift <= {shift[30:0], sym_bit};
        cnt   <= cnt + 6'd1;
      end
      if (par_ld) par_bit <= sym_bit;
    end
  end

  // Output word, valid/ack handshake and registered error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      data        <= '0;
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err  <= perr_nxt;
      frame_err   <= ferr_nxt;
      overrun_err <= commit & valid & ~ack;
      if (commit) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (valid && ack) begin
        valid <= 1'b0;
      end
    end
  end

  assign ready = ~valid;

endmodule

// File: tb/tb_sl_rx_deframer.sv
// Randomized scoreboard bench for sl_rx_deframer: frame-level reference model feeds an expectation queue.
// Latency: valid rise is checked SYNC_STAGES+1 cycles after STOP release on the directed first frame.
// Backpressure: consumer acks automatically, or holds off / acks on the commit cycle in directed cases.
`timescale 1ns/1ps
module tb_sl_rx_deframer;

  localparam int SS = 2;
  localparam int K_COMMIT = 0;
  localparam int K_PERR   = 1;
  localparam int K_FERR   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        sl0, sl1;
  logic [1:0]  mode;
  logic [31:0] data;
  logic        valid, ack, ready;
  logic        parity_err, frame_err, overrun_err;

  typedef struct {
    int          kind;
    logic [31:0] word;
    logic        ovr;
  } exp_t;

  exp_t        expq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ack_at   = -1;
  int          lat_rel  = -1;
  bit          lat_on   = 1'b0;
  bit          ack_on_commit = 1'b0;
  bit          auto_ack = 1'b1;
  logic [31:0] model_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sl_rx_deframer #(.SYNC_STAGES(SS), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .sl0(sl0), .sl1(sl1), .mode(mode),
    .data(data), .valid(valid), .ack(ack), .ready(ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // One symbol: k=0 BIT0, k=1 BIT1, k=2 STOP; skew>0 staggers the STOP edges of the two lines.
  task automatic sym(input int k, input int skew);
    int w, g;
    w = $urandom_range(1, 3);
    g = $urandom_range(1, 3);
    if (k == 2 && skew > 0) begin
      sl0 = 1'b0;
      repeat (skew) @(negedge clk);
      sl1 = 1'b0;
      repeat (2) @(negedge clk);
      sl0 = 1'b1;
      repeat (skew) @(negedge clk);
      sl1 = 1'b1;
    end else begin
      if (k != 1) sl0 = 1'b0;
      if (k != 0) sl1 = 1'b0;
      repeat (w) @(negedge clk);
      sl0 = 1'b1;
      sl1 = 1'b1;
    end
    if (k == 2) begin
      if (lat_on) lat_rel = cyc;
      if (ack_on_commit) ack_at = cyc + SS;
    end
    repeat (g) @(negedge clk);
  endtask

  // Frame of nb bits (bits[nb-1] first), optional STOP. Expectation derived from bit count and parity.
  task automatic send_frame(input logic [1:0] m, input int nb, input logic [39:0] bits,
                            input bit stop, input int skew, input bit ovr);
    int    n;
    exp_t  e;
    logic [39:0] msk;
    n   = 8 * (int'(m) + 1);
    msk = (40'd1 << nb) - 40'd1;
    e.word = '0;
    e.ovr  = ovr;
    if (stop && nb > 0) begin
      if (nb <= n) begin
        e.kind = K_FERR;
      end else if (nb == n + 1) begin
        if (($countones(bits & msk) % 2) == 1) begin
          e.kind = K_COMMIT;
          e.word = 32'((bits & msk) >> 1);
        end else begin
          e.kind = K_PERR;
        end
      end else begin
        e.kind = K_FERR;
      end
      expq.push_back(e);
    end
    mode = m;
    for (int i = nb - 1; i >= 0; i--) begin
      sym(bits[i] ? 1 : 0, 0);
      if (nb >= 3 && i == nb - 3) mode = 2'($urandom);
    end
    if (stop) sym(2, skew);
    repeat ($urandom_range(2, 5)) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (expq.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected events never seen", expq.size());
      expq.delete();
    end
  endtask

  // Monitor: detect commits/errors at the outputs and compare against the queue head; also drives ack.
  initial begin
    logic pv, pa, commit;
    int   nev;
    exp_t e;
    pv  = 1'b0;
    pa  = 1'b0;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      commit = valid && (!pv || pa || overrun_err);
      chk("ready_vs_valid", 32'(ready), 32'(!valid));
      if (lat_rel >= 0 && cyc == lat_rel + SS) chk("valid_before_latency", 32'(valid), 32'd0);
      if (lat_rel >= 0 && cyc == lat_rel + SS + 1) begin
        chk("valid_at_latency", 32'(valid), 32'd1);
        lat_rel = -1;
      end
      nev = int'(commit) + int'(parity_err) + int'(frame_err);
      if (nev > 1) chk("single_event", 32'(nev), 32'd1);
      if (nev > 0) begin
        if (expq.size() == 0) begin
          chk("unexpected_event", 32'(nev), 32'd0);
        end else begin
          e = expq.pop_front();
          chk("event_kind", commit ? 32'd0 : (parity_err ? 32'd1 : 32'd2), 32'(e.kind));
          if (commit) begin
            chk("commit_data", data, e.word);
            chk("overrun_flag", 32'(overrun_err), 32'(e.ovr));
            model_data = e.word;
          end else begin
            chk("data_held_on_err", data, model_data);
          end
        end
      end
      pv  = valid;
      ack = (cyc == ack_at) || (auto_ack && valid);
      pa  = ack;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [1:0]  m;
    logic [39:0] w;
    int          n, r;
    reset = 1'b1;
    sl0   = 1'b1;
    sl1   = 1'b1;
    mode  = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_data", data, 32'd0);
    chk("reset_errs", {29'd0, parity_err, frame_err, overrun_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 0x86, parity 0, with latency check on the STOP release.
    lat_on = 1'b1;
    send_frame(2'b00, 9, 40'h10C, 1'b1, 0, 1'b0);
    lat_on = 1'b0;
    drain();
    chk("ack_clears_valid", 32'(valid), 32'd0);

    // 0xDEADBEEF, straight and with skewed STOP edges.
    send_frame(2'b11, 33, (40'hDEADBEEF << 1) | 40'd1, 1'b1, 0, 1'b0);
    send_frame(2'b11, 33, (40'hDEADBEEF << 1) | 40'd1, 1'b1, 3, 1'b0);
    drain();

    // Bad parity: error, data held, no valid.
    send_frame(2'b00, 9, 40'h10D, 1'b1, 0, 1'b0);
    drain();
    chk("perr_no_valid", 32'(valid), 32'd0);

    // Short frame, long frame, then a good 0x55.
    send_frame(2'b00, 5, 40'h16, 1'b1, 0, 1'b0);
    send_frame(2'b00, 10, 40'h2A5, 1'b1, 0, 1'b0);
    send_frame(2'b00, 9, 40'hAB, 1'b1, 0, 1'b0);
    drain();

    // Overrun, then ack exactly on the commit cycle of a third frame.
    auto_ack = 1'b0;
    send_frame(2'b00, 9, 40'h23, 1'b1, 0, 1'b0);
    send_frame(2'b00, 9, 40'h45, 1'b1, 0, 1'b1);
    ack_on_commit = 1'b1;
    send_frame(2'b00, 9, 40'h67, 1'b1, 0, 1'b0);
    ack_on_commit = 1'b0;
    drain();
    auto_ack = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized frames of every shape.
    for (int f = 0; f < 40; f++) begin
      m = 2'($urandom);
      n = 8 * (int'(m) + 1);
      r = $urandom_range(0, 9);
      w = {8'($urandom), 32'($urandom)} & ((40'd1 << n) - 40'd1);
      if (r <= 5 || r == 9)
        send_frame(m, n + 1, (w << 1) | {39'd0, ~^w}, 1'b1, (r == 9) ? 2 : 0, 1'b0);
      else if (r == 6)
        send_frame(m, n + 1, (w << 1) | {39'd0, ^w}, 1'b1, 0, 1'b0);
      else if (r == 7)
        send_frame(m, $urandom_range(0, n), w, 1'b1, 0, 1'b0);
      else
        send_frame(m, $urandom_range(n + 2, n + 4), {8'($urandom), 32'($urandom)}, 1'b1, 0, 1'b0);
    end
    drain();

`ifdef SL_RX_TIMEOUT_EN
    // Three bits then silence: timeout closes the frame.
    expq.push_back('{kind: K_FERR, word: 32'd0, ovr: 1'b0});
    send_frame(2'b01, 3, 40'h5, 1'b0, 0, 1'b0);
    repeat (30) @(negedge clk);
    drain();
`endif

    // Reset mid-frame, then a clean frame decodes.
    send_frame(2'b10, 3, 40'h3, 1'b0, 0, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_valid", 32'(valid), 32'd0);
    chk("midreset_ready", 32'(ready), 32'd1);
    chk("midreset_data", data, 32'd0);
    chk("midreset_errs", {29'd0, parity_err, frame_err, overrun_err}, 32'd0);
    model_data = '0;
    reset = 1'b0;
    @(negedge clk);
    send_frame(2'b00, 9, (40'h5A << 1) | 40'd1, 1'b1, 0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
